audio_controller: RTL and testbench

AUDIO_CONTROLLER -- requirements
Module: audio_controller

---
 rtl/audio_controller.sv | 261 ++++++++++++++++++++++++++
 tb/tb_audio_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_controller.sv
// Purpose: I2S codec bridge; ADC frames are pushed into a show-ahead input FIFO, and the output FIFO feeds the DAC.
// Latency: codec clock edges seen 3 clocks after the pin; input pair visible ~4 clocks after the closing ADCLRCK fall.
// Backpressure: full input FIFO drops the new ADC pair; full output FIFO ignores writes; an empty output FIFO plays silence.

// Purpose: generic show-ahead FIFO with a clear input and registered status flags.
// Latency: a push is visible at the head one clock later; a pop advances the head the next clock.
// Backpressure: pushes while full and pops while empty are ignored; clear overrides both.
module audio_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic             not_empty,
    output logic             not_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr  = wr_vld && not_full && !clear;
    assign do_rd  = rd_vld && not_empty && !clear;
    assign rd_dat = not_empty ? mem[rd_ptr] : '0;

    // Occupancy after this cycle's push/pop/clear; drives the registered flags.
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (do_wr && !do_rd) begin
            count_nxt = count + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers wrap naturally at the power-of-two depth; the counter tells full from empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            not_empty <= 1'b0;
            not_full  <= 1'b1;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + AW'(1);
                if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            not_empty <= (count_nxt != '0);
            not_full  <= (count_nxt != CW'(DEPTH));
        end
    end

    // Storage is not reset; the flags gate what is visible.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

module audio_controller #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  clear_audio_in_memory,
    input  logic                  read_audio_in,
    input  logic                  clear_audio_out_memory,
    input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                  write_audio_out,
    input  logic                  AUD_ADCDAT,
    inout  wire                   AUD_BCLK,
    inout  wire                   AUD_ADCLRCK,
    inout  wire                   AUD_DACLRCK,
    output logic                  audio_in_available,
    output logic [DATA_WIDTH-1:0] left_channel_audio_in,
    output logic [DATA_WIDTH-1:0] right_channel_audio_in,
    output logic                  audio_out_allowed,
    output logic                  AUD_XCK,
    output logic                  AUD_DACDAT
);
    localparam int PW = $clog2(DATA_WIDTH);
    localparam int NW = PW + 1;
    localparam logic [NW-1:0] BITS = NW'(DATA_WIDTH);

    // The codec masters all serial clocks; we only listen.
    assign AUD_BCLK    = 1'bz;
    assign AUD_ADCLRCK = 1'bz;
    assign AUD_DACLRCK = 1'bz;

    logic [2:0] bclk_sr;
    logic [2:0] adclrck_sr;
    logic [2:0] daclrck_sr;
    logic [1:0] adcdat_sr;

    // Two synchronizer stages plus one history stage for edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            bclk_sr    <= '0;
            adclrck_sr <= '0;
            daclrck_sr <= '0;
            adcdat_sr  <= '0;
        end else begin
            bclk_sr    <= {bclk_sr[1:0], AUD_BCLK};
            adclrck_sr <= {adclrck_sr[1:0], AUD_ADCLRCK};
            daclrck_sr <= {daclrck_sr[1:0], AUD_DACLRCK};
            adcdat_sr  <= {adcdat_sr[0], AUD_ADCDAT};
        end
    end

    logic bclk_rise, bclk_fall, adc_rise, adc_fall, dac_rise, dac_fall;
    assign bclk_rise = bclk_sr[1] & ~bclk_sr[2];
    assign bclk_fall = ~bclk_sr[1] & bclk_sr[2];
    assign adc_rise  = adclrck_sr[1] & ~adclrck_sr[2];
    assign adc_fall  = ~adclrck_sr[1] & adclrck_sr[2];
    assign dac_rise  = daclrck_sr[1] & ~daclrck_sr[2];
    assign dac_fall  = ~daclrck_sr[1] & daclrck_sr[2];

    logic xck_div;

    // Master clock: toggle every second CLOCK_50 edge.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            xck_div <= 1'b0;
            AUD_XCK <= 1'b0;
        end else begin
            xck_div <= ~xck_div;
            if (xck_div) AUD_XCK <= ~AUD_XCK;
        end
    end

    logic                  adc_skip;
    logic                  adc_started;
    logic                  adc_have_left;
    logic [NW-1:0]         adc_cnt;
    logic [PW-1:0]         adc_pos;
    logic [DATA_WIDTH-1:0] adc_shift;
    logic [DATA_WIDTH-1:0] adc_left;

    assign adc_pos = PW'(DATA_WIDTH - 1) - adc_cnt[PW-1:0];

    // ADC capture: MSB-first by bit position so short words zero-fill the LSBs.
    // A left word only counts if it started at a falling LRCK edge seen since reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            adc_skip      <= 1'b1;
            adc_started   <= 1'b0;
            adc_have_left <= 1'b0;
            adc_cnt       <= '0;
            adc_shift     <= '0;
            adc_left      <= '0;
        end else if (adc_rise || adc_fall) begin
            adc_skip  <= 1'b1;
            adc_cnt   <= '0;
            adc_shift <= '0;
            if (adc_rise) begin
                adc_left      <= adc_shift;
                adc_have_left <= adc_started;
            end else begin
                adc_have_left <= 1'b0;
                adc_started   <= 1'b1;
            end
        end else if (bclk_rise) begin
            if (adc_skip) begin
                adc_skip <= 1'b0;
            end else if (adc_cnt < BITS) begin
                adc_shift[adc_pos] <= adcdat_sr[1];
                adc_cnt            <= adc_cnt + NW'(1);
            end
        end
    end

    logic                    in_not_full;
    logic                    in_wr_vld;
    logic [2*DATA_WIDTH-1:0] in_rd_dat;

    assign in_wr_vld = adc_fall && adc_have_left && in_not_full;

    audio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*DATA_WIDTH)) u_in_fifo (
        .clk       (CLOCK_50),
        .reset     (reset),
        .clear     (clear_audio_in_memory),
        .wr_vld    (in_wr_vld),
        .wr_dat    ({adc_left, adc_shift}),
        .rd_vld    (read_audio_in),
        .rd_dat    (in_rd_dat),
        .not_empty (audio_in_available),
        .not_full  (in_not_full)
    );

    assign left_channel_audio_in  = in_rd_dat[2*DATA_WIDTH-1:DATA_WIDTH];
    assign right_channel_audio_in = in_rd_dat[DATA_WIDTH-1:0];

    logic                    out_not_empty;
    logic                    out_rd_vld;
    logic [2*DATA_WIDTH-1:0] out_rd_dat;

    assign out_rd_vld = dac_fall && out_not_empty;

    audio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*DATA_WIDTH)) u_out_fifo (
        .clk       (CLOCK_50),
        .reset     (reset),
        .clear     (clear_audio_out_memory),
        .wr_vld    (write_audio_out),
        .wr_dat    ({left_channel_audio_out, right_channel_audio_out}),
        .rd_vld    (out_rd_vld),
        .rd_dat    (out_rd_dat),
        .not_empty (out_not_empty),
        .not_full  (audio_out_allowed)
    );

    logic [DATA_WIDTH-1:0] dac_left;
    logic [DATA_WIDTH-1:0] dac_right;
    logic [NW-1:0]         dac_cnt;
    logic [PW-1:0]         dac_pos;

    assign dac_pos = PW'(DATA_WIDTH - 1) - dac_cnt[PW-1:0];

    // DAC playback: the BCLK fall coinciding with an LRCK edge is the delay slot,
    // so the next fall drives the MSB; once the word is out, hold the line low.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            dac_left   <= '0;
            dac_right  <= '0;
            dac_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
        end else if (dac_rise || dac_fall) begin
            dac_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
            if (dac_fall) begin
                dac_left  <= out_not_empty ? out_rd_dat[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
                dac_right <= out_not_empty ? out_rd_dat[DATA_WIDTH-1:0] : '0;
            end
        end else if (bclk_fall) begin
            if (dac_cnt < BITS) begin
                AUD_DACDAT <= daclrck_sr[1] ? dac_right[dac_pos] : dac_left[dac_pos];
                dac_cnt    <= dac_cnt + NW'(1);
            end else begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_audio_controller.sv
// Purpose: randomized bench for audio_controller with a queue-based model of both FIFOs and an I2S codec.
// Latency: the codec runs BCLK at 12 clocks/period with 36 slots per channel; status is sampled after settling.
// Backpressure: the model drops pushes at 16 entries and plays zeros from an empty output queue.
module tb_audio_controller;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int HALF  = 6;
    localparam int SLOTS = 36;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic          reset, clr_in, rd_in, clr_out, wr_out, adcdat;
    logic [DW-1:0] lo, ro;
    logic          bclk_drv, lrck_drv;
    wire           aud_bclk, aud_adclrck, aud_daclrck;
    logic          avail, allowed, xck, dacdat;
    logic [DW-1:0] li, ri;

    assign aud_bclk    = bclk_drv;
    assign aud_adclrck = lrck_drv;
    assign aud_daclrck = lrck_drv;

    audio_controller #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .clear_audio_in_memory  (clr_in),
        .read_audio_in          (rd_in),
        .clear_audio_out_memory (clr_out),
        .left_channel_audio_out (lo),
        .right_channel_audio_out(ro),
        .write_audio_out        (wr_out),
        .AUD_ADCDAT             (adcdat),
        .AUD_BCLK               (aud_bclk),
        .AUD_ADCLRCK            (aud_adclrck),
        .AUD_DACLRCK            (aud_daclrck),
        .audio_in_available     (avail),
        .left_channel_audio_in  (li),
        .right_channel_audio_in (ri),
        .audio_out_allowed      (allowed),
        .AUD_XCK                (xck),
        .AUD_DACDAT             (dacdat)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: contents of both FIFOs, the pair the DAC is playing,
    // and the last completed ADC frame awaiting its closing LRCK fall.
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] dac_play;
    logic [63:0] pending;
    bit          pending_vld;
    bit          tb_started;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        dac_play    = '0;
        pending_vld = 1'b0;
        tb_started  = 1'b0;
    endtask

    task automatic model_fall();
        if (pending_vld && in_q.size() < DEPTH) in_q.push_back(pending);
        pending_vld = 1'b0;
        dac_play    = (out_q.size() != 0) ? out_q.pop_front() : 64'd0;
        tb_started  = 1'b1;
    endtask

    task automatic lrck_fall();
        lrck_drv = 1'b0;
        model_fall();
        wait_clk(10);
    endtask

    task automatic check_in(input string tag);
        logic [63:0] e;
        e = (in_q.size() != 0) ? in_q[0] : 64'd0;
        check({tag, "_avail"}, 64'(avail), 64'(in_q.size() != 0));
        check({tag, "_left"},  64'(li), 64'(e[63:32]));
        check({tag, "_right"}, 64'(ri), 64'(e[31:0]));
    endtask

    task automatic read_in();
        rd_in = 1'b1;
        wait_clk(1);
        rd_in = 1'b0;
        if (in_q.size() != 0) void'(in_q.pop_front());
    endtask

    task automatic write_out(input logic [31:0] l, input logic [31:0] r);
        lo = l;
        ro = r;
        wr_out = 1'b1;
        wait_clk(1);
        wr_out = 1'b0;
        if (out_q.size() < DEPTH) out_q.push_back({l, r});
    endtask

    // One I2S frame (left then right); rst_k >= 0 pulses reset at that right-channel slot.
    task automatic codec_frame(input logic [31:0] l, input logic [31:0] r, input int rst_k);
        logic [31:0] word, dl, dr;
        logic [63:0] playing;
        bit ok;
        if (lrck_drv) lrck_fall();
        ok = tb_started;
        playing = dac_play;
        dl = '0;
        dr = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (ch == 1) lrck_drv = 1'b1;
            word = (ch == 1) ? r : l;
            for (int k = 0; k < SLOTS; k++) begin
                if (k >= 1 && k <= DW) adcdat = word[DW-k];
                else adcdat = 1'($urandom);
                wait_clk(HALF);
                bclk_drv = 1'b1;
                if (k >= 1 && k <= DW) begin
                    if (ch == 1) dr[DW-k] = dacdat;
                    else dl[DW-k] = dacdat;
                end
                if (ch == 1 && k == rst_k) begin
                    reset = 1'b0;
                    wait_clk(3);
                    reset = 1'b1;
                    model_reset();
                    ok = 1'b0;
                end
                wait_clk(HALF);
                bclk_drv = 1'b0;
            end
        end
        pending     = {l, r};
        pending_vld = ok;
        if (rst_k < 0) begin
            check("dac_left",  64'(dl), 64'(playing[63:32]));
            check("dac_right", 64'(dr), 64'(playing[31:0]));
        end
    endtask

    task automatic full_frame(input logic [31:0] l, input logic [31:0] r);
        codec_frame(l, r, -1);
        lrck_fall();
    endtask

    // Closing LRCK fall with a one-cycle read/clear landing on the push cycle.
    task automatic aligned_fall(input bit do_read, input bit do_clear);
        lrck_drv = 1'b0;
        wait_clk(2);
        rd_in  = do_read;
        clr_in = do_clear;
        wait_clk(1);
        rd_in  = 1'b0;
        clr_in = 1'b0;
        if (do_clear) begin
            in_q.delete();
            pending_vld = 1'b0;
        end else if (do_read && in_q.size() != 0) begin
            void'(in_q.pop_front());
        end
        model_fall();
        wait_clk(8);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic x[16];
        int bad, ones;
        reset = 1'b0; clr_in = 1'b0; rd_in = 1'b0; clr_out = 1'b0; wr_out = 1'b0;
        adcdat = 1'b0; lo = '0; ro = '0; bclk_drv = 1'b0; lrck_drv = 1'b1;
        model_reset();
        wait_clk(4);
        check("rst_avail",   64'(avail), 64'd0);
        check("rst_allowed", 64'(allowed), 64'd1);
        check("rst_dacdat",  64'(dacdat), 64'd0);
        check("rst_xck",     64'(xck), 64'd0);
        check("rst_left_in", 64'(li), 64'd0);

        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_clk(1);
            x[i] = xck;
        end
        bad = 0;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) ones++;
            if (i >= 2 && x[i] == x[i-2]) bad++;
        end
        check("xck_half_period", 64'(bad), 64'd0);
        check("xck_duty", 64'(ones), 64'd8);
        check("idle_avail",   64'(avail), 64'd0);
        check("idle_allowed", 64'(allowed), 64'd1);
        check("idle_dacdat",  64'(dacdat), 64'd0);

        // Directed ADC pair, then pop it.
        full_frame(32'hA5A5_0001, 32'h5A5A_0002);
        check_in("adc_pair");
        read_in();
        check_in("adc_pop");

        // Directed DAC pair, then silence.
        write_out(32'h8000_0001, 32'h0000_FFFF);
        for (int i = 0; i < 3; i++) full_frame($urandom, $urandom);
        while (in_q.size() != 0) begin
            read_in();
            check_in("drain_a");
        end

        // Fill the output FIFO, overflow it, and overflow the input FIFO.
        for (int i = 0; i < DEPTH; i++) write_out($urandom, $urandom);
        wait_clk(1);
        check("out_full", 64'(allowed), 64'(out_q.size() < DEPTH));
        write_out(32'hDEAD_BEEF, 32'hFEED_F00D);
        check("out_full_17", 64'(allowed), 64'(out_q.size() < DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) full_frame($urandom, $urandom);
        check("out_drained", 64'(allowed), 64'd1);
        check_in("in_full");
        while (in_q.size() != 0) begin
            read_in();
            check_in("drain_b");
        end

        // Simultaneous pop and push at occupancy 1.
        full_frame($urandom, $urandom);
        codec_frame($urandom, $urandom, -1);
        aligned_fall(1'b1, 1'b0);
        check_in("push_pop");
        read_in();
        check_in("push_pop_drain");

        // Clear colliding with a push.
        full_frame($urandom, $urandom);
        codec_frame($urandom, $urandom, -1);
        aligned_fall(1'b0, 1'b1);
        check_in("clear_push");

        // Output FIFO clear leaves silence.
        for (int i = 0; i < 3; i++) write_out($urandom, $urandom);
        clr_out = 1'b1;
        wait_clk(1);
        clr_out = 1'b0;
        out_q.delete();
        check("clear_out_allowed", 64'(allowed), 64'd1);
        full_frame($urandom, $urandom);
        full_frame($urandom, $urandom);
        while (in_q.size() != 0) begin
            read_in();
            check_in("drain_c");
        end

        // Reset in the middle of a frame: no partial pair, output FIFO emptied.
        write_out($urandom, $urandom);
        codec_frame($urandom, $urandom, 10);
        lrck_fall();
        check_in("mid_reset");
        check("mid_reset_allowed", 64'(allowed), 64'd1);
        check("mid_reset_dacdat", 64'(dacdat), 64'd0);
        full_frame($urandom, $urandom);
        check_in("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
